// File: rtl/auth_response_checker_pkg.sv
// Shared types and defaults for the authentication response checker:
// FSM state encoding, default MISR polynomial/seed and the MISR step function.
package auth_response_checker_pkg;

  localparam int AUTH_W = 128;

  localparam logic [AUTH_W-1:0] POLY_DEF = 128'h87;
  localparam logic [AUTH_W-1:0] SEED_DEF = {4{32'hABCD1234}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMPARE = 2'd2
  } state_t;

  // Galois-style MISR step: shift left, fold the dropped MSB back through poly, absorb d.
  function automatic logic [AUTH_W-1:0] misr_step(
    input logic [AUTH_W-1:0] misr,
    input logic [AUTH_W-1:0] d,
    input logic [AUTH_W-1:0] poly
  );
    return {misr[AUTH_W-2:0], 1'b0} ^ (misr[AUTH_W-1] ? poly : '0) ^ d;
  endfunction

endpackage

// File: rtl/auth_response_checker_misr.sv
// W-bit MISR with load (to seed) and step enables.
// Optional per-bit X-mask input when AUTH_RESP_MASK_EN is defined.
module auth_misr
  import auth_response_checker_pkg::*;
#(
  parameter int           W    = AUTH_W,
  parameter logic [W-1:0] POLY = POLY_DEF,
  parameter logic [W-1:0] SEED = SEED_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_data,
`ifdef AUTH_RESP_MASK_EN
  input  logic [W-1:0] i_mask,
`endif
  output logic [W-1:0] o_misr
);

  logic [W-1:0] r_misr;
  logic [W-1:0] w_d;
  logic [W-1:0] w_next;

`ifdef AUTH_RESP_MASK_EN
  assign w_d = i_data & ~i_mask;
`else
  assign w_d = i_data;
`endif

  generate
    if (W == AUTH_W) begin : g_pkg_step
      assign w_next = misr_step(r_misr, w_d, POLY);
    end else begin : g_gen_step
      assign w_next = {r_misr[W-2:0], 1'b0} ^ (r_misr[W-1] ? POLY : '0) ^ w_d;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misr <= SEED;
    end else if (i_load) begin
      r_misr <= SEED;
    end else if (i_step) begin
      r_misr <= w_next;
    end
  end

  assign o_misr = r_misr;

endmodule

// File: rtl/auth_response_checker.sv
// Authentication response checker: discards dummy responses, compacts auth responses
// into a MISR and checks signature/count. Optional X-mask via AUTH_RESP_MASK_EN.
//
// state   | meaning
// IDLE    | waiting for auth_start; results of the last run held
// COLLECT | accepting tagged responses, watchdog running
// COMPARE | one cycle: evaluate signature, pulse check_done, update tamper flag
module auth_response_checker
  import auth_response_checker_pkg::*;
#(
  parameter int           W       = AUTH_W,
  parameter logic [W-1:0] POLY    = POLY_DEF,
  parameter logic [W-1:0] SEED    = SEED_DEF,
  parameter logic [15:0]  TIMEOUT = 16'd1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         auth_start,
  input  logic         resp_valid,
  input  logic         resp_is_dummy,
  input  logic         resp_is_auth,
  input  logic [W-1:0] resp_data,
`ifdef AUTH_RESP_MASK_EN
  input  logic [W-1:0] resp_mask,
`endif
  input  logic [W-1:0] exp_signature,
  input  logic [15:0]  exp_count,
  input  logic         clear_tamper,
  output logic         busy,
  output logic         check_done,
  output logic         sig_match,
  output logic         count_error,
  output logic         tampering_detected,
  output logic [W-1:0] misr_out,
  output logic [15:0]  auth_count,
  output logic [15:0]  dummy_count
);

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0] r_auth_count;
  logic [15:0] r_dummy_count;
  logic [15:0] r_wdog;
  logic        r_check_done;
  logic        r_sig_match;
  logic        r_count_error;
  logic        r_tamper;

  logic        w_arm;
  logic        w_auth_acc;
  logic        w_dummy_acc;
  logic        w_wdog_step;
  logic        w_set_err;
  logic        w_do_cmp;
  logic        w_sig_eq;
  logic [15:0] w_auth_inc;
  logic [15:0] w_wdog_inc;
  logic [W-1:0] w_misr;

  assign w_auth_inc = r_auth_count + 16'd1;
  assign w_wdog_inc = r_wdog + 16'd1;
  assign w_sig_eq   = (w_misr == exp_signature);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_auth_acc  = 1'b0;
    w_dummy_acc = 1'b0;
    w_wdog_step = 1'b0;
    w_set_err   = 1'b0;
    w_do_cmp    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (auth_start) begin
          w_arm       = 1'b1;
          w_state_nxt = (exp_count == 16'd0) ? ST_COMPARE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (auth_start) begin
          w_arm       = 1'b1;
          w_state_nxt = (exp_count == 16'd0) ? ST_COMPARE : ST_COLLECT;
        end else if (resp_valid && resp_is_auth && resp_is_dummy) begin
          w_set_err   = 1'b1;
          w_state_nxt = ST_COMPARE;
        end else if (resp_valid && resp_is_auth) begin
          w_auth_acc = 1'b1;
          if (w_auth_inc == exp_count) begin
            w_state_nxt = ST_COMPARE;
          end
        end else begin
          // Dummies and untagged words both count as a cycle without progress.
          w_dummy_acc = resp_valid && resp_is_dummy;
          w_wdog_step = 1'b1;
          if (w_wdog_inc == TIMEOUT) begin
            w_set_err   = 1'b1;
            w_state_nxt = ST_COMPARE;
          end
        end
      end
      ST_COMPARE: begin
        w_do_cmp    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auth_count  <= '0;
      r_dummy_count <= '0;
      r_wdog        <= '0;
      r_check_done  <= 1'b0;
      r_sig_match   <= 1'b0;
      r_count_error <= 1'b0;
      r_tamper      <= 1'b0;
    end else begin
      r_check_done <= w_do_cmp;
      if (w_arm) begin
        r_auth_count  <= '0;
        r_dummy_count <= '0;
        r_wdog        <= '0;
        r_sig_match   <= 1'b0;
        r_count_error <= 1'b0;
      end else begin
        if (w_auth_acc) begin
          r_auth_count <= w_auth_inc;
          r_wdog       <= '0;
        end
        if (w_dummy_acc && (r_dummy_count != 16'hFFFF)) begin
          r_dummy_count <= r_dummy_count + 16'd1;
        end
        if (w_wdog_step) begin
          r_wdog <= w_wdog_inc;
        end
        if (w_set_err) begin
          r_count_error <= 1'b1;
        end
        if (w_do_cmp) begin
          r_sig_match <= w_sig_eq && !r_count_error;
        end
      end
      // A failure in the same cycle as clear_tamper must win.
      if (w_do_cmp && (!w_sig_eq || r_count_error)) begin
        r_tamper <= 1'b1;
      end else if (clear_tamper) begin
        r_tamper <= 1'b0;
      end
    end
  end

  auth_misr #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_arm),
    .i_step (w_auth_acc),
    .i_data (resp_data),
`ifdef AUTH_RESP_MASK_EN
    .i_mask (resp_mask),
`endif
    .o_misr (w_misr)
  );

  assign busy               = (r_state != ST_IDLE);
  assign check_done         = r_check_done;
  assign sig_match          = r_sig_match;
  assign count_error        = r_count_error;
  assign tampering_detected = r_tamper;
  assign misr_out           = w_misr;
  assign auth_count         = r_auth_count;
  assign dummy_count        = r_dummy_count;

endmodule

// File: tb/tb_auth_response_checker.sv
// Directed bench for auth_response_checker with a result scoreboard; TIMEOUT shortened to 16.
// Build with AUTH_RESP_MASK_EN defined to include the X-mask scenario.
module tb_auth_response_checker;

  localparam logic [127:0] SEED = {4{32'hABCD1234}};
  localparam logic [127:0] POLY = 128'h87;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         auth_start = 1'b0;
  logic         resp_valid = 1'b0;
  logic         resp_is_dummy = 1'b0;
  logic         resp_is_auth = 1'b0;
  logic [127:0] resp_data = '0;
`ifdef AUTH_RESP_MASK_EN
  logic [127:0] resp_mask = '0;
`endif
  logic [127:0] exp_signature = '0;
  logic [15:0]  exp_count = '0;
  logic         clear_tamper = 1'b0;
  logic         busy, check_done, sig_match, count_error, tampering_detected;
  logic [127:0] misr_out;
  logic [15:0]  auth_count, dummy_count;

  auth_response_checker #(.TIMEOUT(16'd16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .auth_start        (auth_start),
    .resp_valid        (resp_valid),
    .resp_is_dummy     (resp_is_dummy),
    .resp_is_auth      (resp_is_auth),
    .resp_data         (resp_data),
`ifdef AUTH_RESP_MASK_EN
    .resp_mask         (resp_mask),
`endif
    .exp_signature     (exp_signature),
    .exp_count         (exp_count),
    .clear_tamper      (clear_tamper),
    .busy              (busy),
    .check_done        (check_done),
    .sig_match         (sig_match),
    .count_error       (count_error),
    .tampering_detected(tampering_detected),
    .misr_out          (misr_out),
    .auth_count        (auth_count),
    .dummy_count       (dummy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  sm;
    logic  ce;
    logic  tp;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [127:0] ref_step(input logic [127:0] s, input logic [127:0] d);
    logic fb;
    fb = s[127];
    s  = s << 1;
    if (fb) s = s ^ POLY;
    return s ^ d;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic arm(input logic [15:0] cnt, input logic [127:0] sig);
    exp_count     = cnt;
    exp_signature = sig;
    auth_start    = 1'b1;
    tick();
    auth_start    = 1'b0;
  endtask

  task automatic send(input logic is_auth, input logic is_dummy, input logic [127:0] d);
    resp_valid    = 1'b1;
    resp_is_auth  = is_auth;
    resp_is_dummy = is_dummy;
    resp_data     = d;
    tick();
    resp_valid    = 1'b0;
    resp_is_auth  = 1'b0;
    resp_is_dummy = 1'b0;
  endtask

  task automatic expect_result(input logic sm, input logic ce, input logic tp, input string tag);
    exp_t e;
    e.sm = sm; e.ce = ce; e.tp = tp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int exp_lat, input int budget);
    int   n;
    exp_t e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!check_done && n < budget);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_done"}, check_done, 1'b1);
      if (check_done) begin
        chk({e.tag, "_latency"}, n, exp_lat);
        chk({e.tag, "_sig_match"}, sig_match, e.sm);
        chk({e.tag, "_count_error"}, count_error, e.ce);
        chk({e.tag, "_tamper"}, tampering_detected, e.tp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] g;
    logic [127:0] w[8];

    // reset state
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_check_done", check_done, 0);
    chk("rst_sig_match", sig_match, 0);
    chk("rst_count_error", count_error, 0);
    chk("rst_tamper", tampering_detected, 0);
    chk("rst_misr", misr_out, SEED);
    chk("rst_counts", {auth_count, dummy_count}, 0);
    rst_n = 1'b1;
    tick();

    // single zero word, pass
    g = ref_step(SEED, '0);
    arm(16'd1, g);
    chk("t1_busy", busy, 1);
    chk("t1_misr_seed", misr_out, SEED);
    expect_result(1'b1, 1'b0, 1'b0, "t1");
    send(1'b1, 1'b0, '0);
    chk("t1_auth_count", auth_count, 1);
    chk("t1_misr", misr_out, g);
    wait_done(1, 8);
    tick();
    chk("t1_pulse", check_done, 0);
    chk("t1_idle", busy, 0);

    // dummies then one corrupted auth word
    g = SEED;
    for (int i = 0; i < 4; i++) begin
      w[i] = rnd128();
      g    = ref_step(g, w[i]);
    end
    arm(16'd4, g);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1, rnd128());
    chk("t2_misr_after_dummies", misr_out, SEED);
    expect_result(1'b0, 1'b0, 1'b1, "t2");
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, (i == 2) ? (w[i] ^ (128'd1 << 37)) : w[i]);
    wait_done(1, 8);
    chk("t2_dummy_count", dummy_count, 10);
    chk("t2_auth_count", auth_count, 4);
    repeat (5) tick();
    chk("t2_tamper_held", tampering_detected, 1);
    clear_tamper = 1'b1;
    tick();
    clear_tamper = 1'b0;
    chk("t2_tamper_cleared", tampering_detected, 0);

    // starvation: 3 of 8 words, then silence
    arm(16'd8, rnd128());
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, rnd128());
    expect_result(1'b0, 1'b1, 1'b1, "t3");
    wait_done(17, 40);
    chk("t3_auth_count", auth_count, 3);

    // both tags set, clear_tamper held (failure must win), auth_start during COMPARE ignored
    clear_tamper = 1'b1;
    arm(16'd5, SEED);
    chk("t4_tamper_cleared", tampering_detected, 0);
    send(1'b1, 1'b1, rnd128());
    auth_start = 1'b1;
    expect_result(1'b0, 1'b1, 1'b1, "t4");
    wait_done(1, 4);
    auth_start   = 1'b0;
    clear_tamper = 1'b0;
    chk("t4_start_ignored", busy, 0);

    // async reset mid-COLLECT
    arm(16'd4, SEED);
    send(1'b1, 1'b0, rnd128());
    send(1'b1, 1'b0, rnd128());
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_tamper", tampering_detected, 0);
    chk("t7_misr", misr_out, SEED);
    chk("t7_auth_count", auth_count, 0);
    rst_n = 1'b1;
    tick();

    // exp_count == 0
    arm(16'd0, SEED);
    expect_result(1'b1, 1'b0, 1'b0, "t5");
    wait_done(1, 4);

    // restart mid-COLLECT
    g = SEED;
    for (int i = 0; i < 6; i++) begin
      w[i] = rnd128();
      g    = ref_step(g, w[i]);
    end
    arm(16'd6, g);
    send(1'b1, 1'b0, w[0]);
    send(1'b1, 1'b0, w[1]);
    arm(16'd6, g);
    chk("t6_restart_count", auth_count, 0);
    chk("t6_restart_misr", misr_out, SEED);
    chk("t6_no_done", check_done, 0);
    chk("t6_busy", busy, 1);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, w[i]);
    expect_result(1'b1, 1'b0, 1'b0, "t6");
    send(1'b1, 1'b0, w[5]);
    wait_done(1, 4);

`ifdef AUTH_RESP_MASK_EN
    // all-ones mask makes any data equivalent to zero data
    g = SEED;
    for (int i = 0; i < 3; i++) g = ref_step(g, '0);
    resp_mask = '1;
    arm(16'd3, g);
    send(1'b1, 1'b0, rnd128());
    send(1'b1, 1'b0, rnd128());
    expect_result(1'b1, 1'b0, 1'b0, "t8");
    send(1'b1, 1'b0, rnd128());
    wait_done(1, 4);
    resp_mask = '0;
`endif

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
